// File: rtl/alu_isa_pkg.sv
// Shared definitions for the ALU issue path: datapath widths, ALU opcode
// encodings, instruction field positions and the issue-controller states.
package alu_isa_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    // Instr layout: [15:13] opcode, [12] shift, [11:9] rd, [8:6] rs1, [5:3] rs2
    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 13;
    localparam int SHIFT_BIT = 12;
    localparam int RD_MSB    = 11;
    localparam int RD_LSB    = 9;
    localparam int RS1_MSB   = 8;
    localparam int RS1_LSB   = 6;
    localparam int RS2_MSB   = 5;
    localparam int RS2_LSB   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU issue controller.
// Ports: Clk/Reset_n (async active-low, clears every register),
//        one write port (we/waddr/wdata), two operand read ports
//        (raddr1/rdata1, raddr2/rdata2) and a debug read port
//        (dbg_addr/dbg_data). All reads are combinational; r0 reads as 0
//        and writes to r0 are dropped.
module alu_regfile #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr1,
    output logic [WIDTH-1:0]         rdata1,
    input  logic [$clog2(DEPTH)-1:0] raddr2,
    output logic [WIDTH-1:0]         rdata2,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    output logic [WIDTH-1:0]         dbg_data
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1   = (raddr1   == '0) ? '0 : regs_q[raddr1];
    assign rdata2   = (raddr2   == '0) ? '0 : regs_q[raddr2];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of a combinational 16-bit ALU.
// Accepts register-form instructions on Instr_Valid/Instr_Ready, reads the
// sources from an internal register file, drives the ALU from registered
// Operand1/Operand2/Alu_Opcode/Shift, samples Result/Zero_Out and writes the
// result back to rd (Done pulses in the writeback cycle).
// Ports: Clk, Reset_n (async active-low); Instr_Valid/Instr_Ready/Instr;
//        ALU side Operand1/Operand2/Alu_Opcode/Shift out, Result/Zero_Out in;
//        Done/Wb_Data/Zero_Flag status; Rf_Wr_* preload (IDLE only);
//        Rf_Rd_Addr/Rf_Rd_Data combinational debug read.
//
// state | meaning
// IDLE  | ready; accepts an instruction, honours preload writes
// READ  | register sources and opcode onto the ALU inputs
// EXEC  | wait EXEC_CYCLES for the ALU; sample result on the last cycle
// WB    | Done pulse, write Wb_Data to rd
module alu_issue_ctrl import alu_isa_pkg::*; #(
    parameter int DATA_W      = 16,
    parameter int REG_COUNT   = 8,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         Instr_Valid,
    output logic                         Instr_Ready,
    input  logic [15:0]                  Instr,
    output logic [DATA_W-1:0]            Operand1,
    output logic [DATA_W-1:0]            Operand2,
    output logic [2:0]                   Alu_Opcode,
    output logic                         Shift,
    input  logic [DATA_W-1:0]            Result,
    input  logic                         Zero_Out,
    output logic                         Done,
    output logic [DATA_W-1:0]            Wb_Data,
    output logic                         Zero_Flag,
    input  logic                         Rf_Wr_En,
    input  logic [$clog2(REG_COUNT)-1:0] Rf_Wr_Addr,
    input  logic [DATA_W-1:0]            Rf_Wr_Data,
    input  logic [$clog2(REG_COUNT)-1:0] Rf_Rd_Addr,
    output logic [DATA_W-1:0]            Rf_Rd_Data
);

    localparam int AW    = $clog2(REG_COUNT);
    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    state_e             state_q,  state_d;
    logic [15:0]        instr_q,  instr_d;
    logic [DATA_W-1:0]  op1_q,    op1_d;
    logic [DATA_W-1:0]  op2_q,    op2_d;
    logic [2:0]         opc_q,    opc_d;
    logic               shift_q,  shift_d;
    logic [DATA_W-1:0]  wb_q,     wb_d;
    logic               zf_q,     zf_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    logic               rf_we;
    logic [AW-1:0]      rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic [DATA_W-1:0]  rs1_data;
    logic [DATA_W-1:0]  rs2_data;

    alu_regfile #(
        .WIDTH (DATA_W),
        .DEPTH (REG_COUNT)
    ) u_regfile (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr1   (instr_q[RS1_MSB:RS1_LSB]),
        .rdata1   (rs1_data),
        .raddr2   (instr_q[RS2_MSB:RS2_LSB]),
        .rdata2   (rs2_data),
        .dbg_addr (Rf_Rd_Addr),
        .dbg_data (Rf_Rd_Data)
    );

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        opc_d    = opc_q;
        shift_d  = shift_q;
        wb_d     = wb_q;
        zf_d     = zf_q;
        cnt_d    = cnt_q;
        rf_we    = 1'b0;
        rf_waddr = Rf_Wr_Addr;
        rf_wdata = Rf_Wr_Data;

        case (state_q)
            IDLE: begin
                // Preload and accept may share a cycle; the preload lands on
                // the accept edge so READ already sees it.
                rf_we = Rf_Wr_En;
                if (Instr_Valid) begin
                    instr_d = Instr;
                    state_d = READ;
                end
            end
            READ: begin
                op1_d   = rs1_data;
                op2_d   = rs2_data;
                opc_d   = instr_q[OPC_MSB:OPC_LSB];
                shift_d = instr_q[SHIFT_BIT];
                cnt_d   = CNT_W'(EXEC_CYCLES - 1);
                state_d = EXEC;
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    wb_d    = Result;
                    zf_d    = Zero_Out;
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WB: begin
                rf_we    = 1'b1;
                rf_waddr = instr_q[RD_MSB:RD_LSB];
                rf_wdata = wb_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            instr_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            opc_q   <= '0;
            shift_q <= 1'b0;
            wb_q    <= '0;
            zf_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            opc_q   <= opc_d;
            shift_q <= shift_d;
            wb_q    <= wb_d;
            zf_q    <= zf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Instr_Ready = (state_q == IDLE);
    assign Done        = (state_q == WB);
    assign Operand1    = op1_q;
    assign Operand2    = op2_q;
    assign Alu_Opcode  = opc_q;
    assign Shift       = shift_q;
    assign Wb_Data     = wb_q;
    assign Zero_Flag   = zf_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
    import alu_isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        rf_wr_en = 1'b0;
    logic [2:0]  rf_wr_addr = '0;
    logic [15:0] rf_wr_data = '0;
    logic [2:0]  rf_rd_addr = '0;

    // DUT A: EXEC_CYCLES=1
    logic        ready_a, shift_a, zero_a, done_a, zf_a;
    logic [15:0] op1_a, op2_a, res_a, wb_a, rd_a;
    logic [2:0]  opc_a;
    // DUT B: EXEC_CYCLES=3
    logic        ready_b, shift_b, zero_b, done_b, zf_b;
    logic [15:0] op1_b, op2_b, res_b, wb_b, rd_b;
    logic [2:0]  opc_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_model(input logic [2:0] op, input logic sh,
                                              input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            default: r = '0;
        endcase
        if (sh) r = r << 1;
        return r;
    endfunction

    always_comb begin
        res_a  = alu_model(opc_a, shift_a, op1_a, op2_a);
        zero_a = (res_a == 16'h0);
        res_b  = alu_model(opc_b, shift_b, op1_b, op2_b);
        zero_b = (res_b == 16'h0);
    end

    alu_issue_ctrl #(.DATA_W(16), .REG_COUNT(8), .EXEC_CYCLES(1)) dut_a (
        .Clk(clk), .Reset_n(rst_n), .Instr_Valid(instr_valid), .Instr_Ready(ready_a),
        .Instr(instr), .Operand1(op1_a), .Operand2(op2_a), .Alu_Opcode(opc_a),
        .Shift(shift_a), .Result(res_a), .Zero_Out(zero_a), .Done(done_a),
        .Wb_Data(wb_a), .Zero_Flag(zf_a), .Rf_Wr_En(rf_wr_en), .Rf_Wr_Addr(rf_wr_addr),
        .Rf_Wr_Data(rf_wr_data), .Rf_Rd_Addr(rf_rd_addr), .Rf_Rd_Data(rd_a)
    );

    alu_issue_ctrl #(.DATA_W(16), .REG_COUNT(8), .EXEC_CYCLES(3)) dut_b (
        .Clk(clk), .Reset_n(rst_n), .Instr_Valid(instr_valid), .Instr_Ready(ready_b),
        .Instr(instr), .Operand1(op1_b), .Operand2(op2_b), .Alu_Opcode(opc_b),
        .Shift(shift_b), .Result(res_b), .Zero_Out(zero_b), .Done(done_b),
        .Wb_Data(wb_b), .Zero_Flag(zf_b), .Rf_Wr_En(rf_wr_en), .Rf_Wr_Addr(rf_wr_addr),
        .Rf_Wr_Data(rf_wr_data), .Rf_Rd_Addr(rf_rd_addr), .Rf_Rd_Data(rd_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        rf_wr_en = 1'b1; rf_wr_addr = a; rf_wr_data = d;
        @(negedge clk);
        rf_wr_en = 1'b0;
    endtask

    // Issue one instruction on DUT A and check operands in EXEC, latency,
    // writeback value/flag, Done pulse width and the destination register.
    task automatic issue(input string tag, input logic [15:0] ins,
                         input logic pre_en, input logic [2:0] pre_addr, input logic [15:0] pre_data,
                         input logic [15:0] e_op1, input logic [15:0] e_op2,
                         input logic [2:0] e_opc, input logic e_sh,
                         input logic [15:0] e_wb, input logic e_z,
                         input logic [2:0] e_rd, input logic [15:0] e_rdval);
        int done_lat;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(ready_a), 32'd1);
        instr = ins; instr_valid = 1'b1;
        rf_wr_en = pre_en; rf_wr_addr = pre_addr; rf_wr_data = pre_data;
        done_lat = 0;
        for (int lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            if (lat == 1) begin
                instr_valid = 1'b0; rf_wr_en = 1'b0;
            end
            if (lat == 2) begin
                chk({tag, "_op1"},   32'(op1_a),   32'(e_op1));
                chk({tag, "_op2"},   32'(op2_a),   32'(e_op2));
                chk({tag, "_opc"},   32'(opc_a),   32'(e_opc));
                chk({tag, "_shift"}, 32'(shift_a), 32'(e_sh));
            end
            if (done_a) begin
                done_lat = lat;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(done_lat), 32'd3);
        chk({tag, "_wb_data"}, 32'(wb_a), 32'(e_wb));
        chk({tag, "_zero"},    32'(zf_a), 32'(e_z));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done_a), 32'd0);
        chk({tag, "_op1_hold"},   32'(op1_a),  32'(e_op1));
        chk({tag, "_wb_hold"},    32'(wb_a),   32'(e_wb));
        rf_rd_addr = e_rd;
        #1;
        chk({tag, "_rd_val"}, 32'(rd_a), 32'(e_rdval));
    endtask

    typedef struct {
        string       tag;
        logic [15:0] instr;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [2:0]  opc;
        logic        sh;
        logic [15:0] wb;
        logic        z;
        logic [2:0]  rd;
        logic [15:0] rdval;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] rdy, dn;
        logic [8:0] exp_rdy, exp_dn;
        int         done_lat;
        logic       seen_done;

        //            tag       instr     op1      op2      opc  sh  wb       z  rd  rdval
        vecs[0] = '{"add_r3",  16'h0650, 16'h0004, 16'h0002, 3'd0, 1'b0, 16'h0006, 1'b0, 3'd3, 16'h0006};
        vecs[1] = '{"sub_r4",  16'h2848, 16'h0004, 16'h0004, 3'd1, 1'b0, 16'h0000, 1'b1, 3'd4, 16'h0000};
        vecs[2] = '{"add_r0",  16'h0050, 16'h0004, 16'h0002, 3'd0, 1'b0, 16'h0006, 1'b0, 3'd0, 16'h0000};
        vecs[3] = '{"and_r7",  16'h4F70, 16'h00F0, 16'h0F0F, 3'd2, 1'b0, 16'h0000, 1'b1, 3'd7, 16'h0000};
        vecs[4] = '{"or_r7",   16'h6F70, 16'h00F0, 16'h0F0F, 3'd3, 1'b0, 16'h0FFF, 1'b0, 3'd7, 16'h0FFF};
        vecs[5] = '{"xor_raw", 16'h86F7, 16'h0006, 16'h0F0F, 3'd4, 1'b0, 16'h0F09, 1'b0, 3'd3, 16'h0F09};
        vecs[6] = '{"add_sh",  16'h1C50, 16'h0004, 16'h0002, 3'd0, 1'b1, 16'h000C, 1'b0, 3'd6, 16'h000C};
        vecs[7] = '{"sub_neg", 16'h248D, 16'h0002, 16'h0004, 3'd1, 1'b0, 16'hFFFE, 1'b0, 3'd2, 16'hFFFE};

        // Reset state
        #12;
        chk("rst_ready",  32'(ready_a), 32'd1);
        chk("rst_done",   32'(done_a),  32'd0);
        chk("rst_op1",    32'(op1_a),   32'd0);
        chk("rst_wb",     32'(wb_a),    32'd0);
        chk("rst_zf",     32'(zf_a),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(ready_a), 32'd1);

        preload(3'd1, 16'h0004);
        preload(3'd2, 16'h0002);
        preload(3'd5, 16'h00F0);
        preload(3'd6, 16'h0F0F);
        preload(3'd0, 16'hBEEF);
        rf_rd_addr = 3'd0;
        #1;
        chk("r0_preload_dropped", 32'(rd_a), 32'd0);

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].tag, vecs[i].instr, 1'b0, 3'd0, 16'h0,
                  vecs[i].op1, vecs[i].op2, vecs[i].opc, vecs[i].sh,
                  vecs[i].wb, vecs[i].z, vecs[i].rd, vecs[i].rdval);
        end

        // Preload r5 in the accept cycle of ADD r4,r5,r1: READ must see it.
        issue("wbr", 16'h0948, 1'b1, 3'd5, 16'h1234,
              16'h1234, 16'h0004, 3'd0, 1'b0, 16'h1238, 1'b0, 3'd4, 16'h1238);

        // Valid held across two ops; preload attempt during EXEC is ignored.
        preload(3'd2, 16'h0002);
        @(negedge clk);
        instr = 16'h0650; instr_valid = 1'b1;
        rdy[0] = ready_a; dn[0] = done_a;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) instr = 16'h6A50;
            if (i == 2) begin rf_wr_en = 1'b1; rf_wr_addr = 3'd1; rf_wr_data = 16'hDEAD; end
            if (i == 3) rf_wr_en = 1'b0;
            if (i == 5) instr_valid = 1'b0;
            rdy[i] = ready_a; dn[i] = done_a;
        end
        exp_rdy = 9'b100010001;
        exp_dn  = 9'b010001000;
        for (int i = 0; i <= 8; i++) begin
            chk($sformatf("b2b_ready_%0d", i), 32'(rdy[i]), 32'(exp_rdy[i]));
            chk($sformatf("b2b_done_%0d", i),  32'(dn[i]),  32'(exp_dn[i]));
        end
        chk("b2b_wb", 32'(wb_a), 32'h0006);
        rf_rd_addr = 3'd1; #1;
        chk("exec_preload_ignored", 32'(rd_a), 32'h0004);
        rf_rd_addr = 3'd5; #1;
        chk("b2b_r5", 32'(rd_a), 32'h0006);

        // EXEC_CYCLES=3 instance from a clean reset.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        preload(3'd1, 16'h0004);
        preload(3'd2, 16'h0002);
        @(negedge clk);
        chk("x3_ready", 32'(ready_b), 32'd1);
        instr = 16'h0650; instr_valid = 1'b1;
        done_lat = 0;
        for (int lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            if (lat == 1) instr_valid = 1'b0;
            if (lat >= 2 && lat <= 4) begin
                chk($sformatf("x3_op1_%0d", lat), 32'(op1_b), 32'h0004);
                chk($sformatf("x3_op2_%0d", lat), 32'(op2_b), 32'h0002);
                chk($sformatf("x3_opc_%0d", lat), 32'(opc_b), 32'd0);
                chk($sformatf("x3_ready_%0d", lat), 32'(ready_b), 32'd0);
            end
            if (done_b) begin
                done_lat = lat;
                break;
            end
        end
        chk("x3_latency", 32'(done_lat), 32'd5);
        chk("x3_wb", 32'(wb_b), 32'h0006);
        @(negedge clk);
        rf_rd_addr = 3'd3; #1;
        chk("x3_r3", 32'(rd_b), 32'h0006);

        // Reset during EXEC aborts the op.
        @(negedge clk);
        instr = 16'h0650; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_done",  32'(done_a),  32'd0);
        chk("abort_op1",   32'(op1_a),   32'd0);
        chk("abort_op2",   32'(op2_a),   32'd0);
        chk("abort_wb",    32'(wb_a),    32'd0);
        chk("abort_wb_b",  32'(wb_b),    32'd0);
        chk("abort_zf",    32'(zf_a),    32'd0);
        chk("abort_ready", 32'(ready_a), 32'd1);
        seen_done = 1'b0;
        for (int a = 1; a < 8; a++) begin
            rf_rd_addr = 3'(a); #1;
            chk($sformatf("abort_r%0d", a), 32'(rd_a), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_rel_ready", 32'(ready_a), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_a || done_b) seen_done = 1'b1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        rf_rd_addr = 3'd3; #1;
        chk("abort_r3_after", 32'(rd_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the 16-bit ALU operand interface (Operand1/Operand2/Alu_Opcode/Shift in, Result/Zero_Out back).
- Accepts register-form instructions over a valid/ready handshake and reads source operands from an internal 8x16 register file.
- Drives the combinational ALU from registered outputs, samples Result/Zero_Out, and writes the result back to the destination register.
- Sits between the instruction fetch stage and the ALU. The register file is preloadable and readable for bring-up and for the bench.

Parameters:
- DATA_W, 16, datapath width; must match ALU operand width.
- REG_COUNT, 8, number of registers; address width is log2 = 3.
- EXEC_CYCLES, 1, cycles the FSM waits for the ALU result to settle; minimum 1.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Instr_Valid  in  1  instruction present.
- Instr_Ready  out  1  controller can accept; high only in IDLE.
- Instr  in  16  [15:13] alu opcode, [12] shift, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] ignored.
- Operand1  out  DATA_W  to ALU, registered.
- Operand2  out  DATA_W  to ALU, registered.
- Alu_Opcode  out  3  to ALU, registered.
- Shift  out  1  to ALU, registered.
- Result  in  DATA_W  from ALU.
- Zero_Out  in  1  from ALU.
- Done  out  1  one-cycle pulse on writeback.
- Wb_Data  out  DATA_W  value written in the Done cycle; holds afterwards.
- Zero_Flag  out  1  sampled Zero_Out of the last completed op.
- Rf_Wr_En  in  1  external register preload strobe.
- Rf_Wr_Addr  in  3  preload address.
- Rf_Wr_Data  in  DATA_W  preload data.
- Rf_Rd_Addr  in  3  debug read address.
- Rf_Rd_Data  out  DATA_W  combinational debug read.

Behaviour:
- **Reset** (async, Reset_n=0):
  - state=IDLE.
  - All registers r0..r7 = 0.
  - Operand1, Operand2, Alu_Opcode, Shift, Wb_Data, Zero_Flag = 0; Done = 0.
  - Instr_Ready = 1 as soon as reset releases, since IDLE is the reset state.
- **Reset mid-operation:** in-flight instruction is aborted, with no writeback and no Done.
- **FSM states:** IDLE -> READ -> EXEC -> WB -> IDLE.
  - IDLE: Instr_Ready=1. If Instr_Valid, latch Instr and go to READ.
  - READ (1 cycle):
    - Operand1 <= R[rs1], Operand2 <= R[rs2].
    - Alu_Opcode <= Instr[15:13], Shift <= Instr[12].
    - Load the exec counter with EXEC_CYCLES-1.
  - EXEC (EXEC_CYCLES cycles): ALU outputs stay stable; counter decrements each cycle. On the final EXEC cycle, latch Result into Wb_Data and Zero_Out into Zero_Flag.
  - WB (1 cycle): Done=1 and R[rd] <= Wb_Data, except that writes to r0 are discarded. Then go to IDLE.
- **Latency and throughput:**
  - Accept-to-Done = 2 + EXEC_CYCLES cycles (default 3).
  - Next accept can happen in the cycle after WB, so back-to-back throughput is one instruction per 3 + EXEC_CYCLES cycles.
- **r0:** reads always return 0, including on Rf_Rd_Data.
- **Operand outputs** hold their values between operations and change only in READ.
- **Instr_Valid outside IDLE** is ignored; the source must hold Instr stable until it is accepted.
- **Preload:**
  - Rf_Wr_En is honoured only in IDLE and ignored in other states.
  - A preload and an instruction accept in the same IDLE cycle: the preload commits on that edge. READ then sees the new value (write-before-read).
- **Read-after-write between instructions:** the WB write is visible to the next instruction's READ; no bypass is needed because the phases are serialised.
- **Arithmetic:** the controller does no arithmetic. Result is used exactly as returned (modulo 2^DATA_W is the ALU's concern).
- **Instr[2:0]** has no effect.

Decomposition:
- Shared package alu_isa_pkg:
  - DATA_W, REG_ADDR_W.
  - Opcode constants: ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_XOR=100.
  - Instr field bit positions.
  - FSM state enum {IDLE, READ, EXEC, WB}.
- One sub-module, alu_regfile:
  - 8xDATA_W storage, async reset to 0, r0 hardwired to 0.
  - Two combinational read ports plus the debug port.
  - Single write port, muxed between preload and WB by the controller.

Test Plan (bench connects a behavioural ALU per alu_isa_pkg):
1. Preload r1=0x0004, r2=0x0002; issue ADD r3,r1,r2 (Instr=0x0650) -> in EXEC cycle: Operand1=0x0004, Operand2=0x0002, Alu_Opcode=000, Shift=0. Done exactly 3 cycles after accept; r3=0x0006, Zero_Flag=0.
2. Issue SUB r4,r1,r1 (Instr=0x2848) -> Wb_Data=0x0000, Zero_Flag=1, r4=0x0000.
3. Issue ADD r0,r1,r2 -> Done pulses with Wb_Data=0x0006; Rf_Rd_Data at addr 0 stays 0x0000.
4. Hold Instr_Valid high across two instructions -> second accepted only in the cycle after the first WB. Instr_Ready low for exactly 3 cycles per op; a Rf_Wr_En pulse during EXEC leaves the register unchanged.
5. EXEC_CYCLES=3 build: ADD r3,r1,r2 -> Done 5 cycles after accept; Alu_Opcode/Operand1/Operand2 stable through all 3 EXEC cycles.
6. Assert Reset_n=0 during EXEC of ADD r3,r1,r2 -> no Done pulse; all registers and outputs 0. After release, Instr_Ready=1 in the first cycle.
